// File: rtl/fpu_rr_scheduler.sv
// Round-robin front end that shares one restart-driven FPU adder among N_REQ clients.
// Optional feature macro: FPU_SCHED_ZERO_BYPASS_EN (answer zero-operand jobs without the FPU).
module fpu_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 32,
    parameter int DW      = 32,
    parameter int SW      = 4
) (
    input  logic                clock_100Khz,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_op_a,
    input  logic [N_REQ*DW-1:0] req_op_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [DW-1:0]       resp_data,
    output logic [SW-1:0]       resp_status,
    output logic                busy,
    output logic                fpu_rst_n,
    output logic [DW-1:0]       fpu_op_a,
    output logic [DW-1:0]       fpu_op_b,
    input  logic [DW-1:0]       fpu_data_in,
    input  logic [SW-1:0]       fpu_status_in,
    output logic [1:0]          state_dbg
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win_idx;
    logic [7:0]    counter;
    logic          win_found;
    logic          grant;
    logic          bypass_hit;
    logic [DW-1:0] win_a;
    logic [DW-1:0] win_b;
    int            cand;

    // Handshake: req_valid[i] stays high until req_ready[i]; the job transfers in the
    // single cycle both are high. req_ready is only ever raised from IDLE, one-hot.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    assign win_a = req_op_a[win_idx*DW +: DW];
    assign win_b = req_op_b[win_idx*DW +: DW];
    assign grant = (state == IDLE) && win_found && !reset;

`ifdef FPU_SCHED_ZERO_BYPASS_EN
    logic [DW-1:0] bypass_data;

    // Magnitude zero (sign ignored) on B wins over a zero A.
    always_comb begin
        bypass_hit  = 1'b0;
        bypass_data = win_a;
        if (win_b[DW-2:0] == '0) begin
            bypass_hit  = 1'b1;
            bypass_data = win_a;
        end else if (win_a[DW-2:0] == '0) begin
            bypass_hit  = 1'b1;
            bypass_data = win_b;
        end
    end
`else
    assign bypass_hit = 1'b0;
`endif

    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_found && !bypass_hit) next_state = ISSUE;
            ISSUE:   next_state = RUN;
            RUN:     if (counter == 8'(LATENCY - 1)) next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
        busy      = (state != IDLE) || (resp_valid != '0);
        state_dbg = state;
    end

    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            fpu_rst_n   <= 1'b0;
            fpu_op_a    <= '0;
            fpu_op_b    <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            counter     <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_status <= '0;
        end else begin
            resp_valid <= '0;
            // The FPU sees exactly one low cycle, aligned with ISSUE.
            fpu_rst_n  <= (next_state != ISSUE);
            if (grant) begin
                rr_ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                owner  <= win_idx;
`ifdef FPU_SCHED_ZERO_BYPASS_EN
                if (bypass_hit) begin
                    resp_data           <= bypass_data;
                    resp_status         <= '0;
                    resp_valid[win_idx] <= 1'b1;
                end else begin
                    fpu_op_a <= win_a;
                    fpu_op_b <= win_b;
                end
`else
                fpu_op_a <= win_a;
                fpu_op_b <= win_b;
`endif
            end
            if (state == ISSUE) begin
                counter <= '0;
            end else if (state == RUN) begin
                counter <= counter + 8'd1;
            end
            if (state == CAPTURE) begin
                resp_data         <= fpu_data_in;
                resp_status       <= fpu_status_in;
                resp_valid[owner] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Bench for fpu_rr_scheduler: stub FPU, randomized and directed requests, scoreboard monitor.
// Honours FPU_SCHED_ZERO_BYPASS_EN the same way the design does.
module tb_fpu_rr_scheduler;
    localparam int N_REQ   = 4;
    localparam int LATENCY = 32;
    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int EW      = 32 + 8 + DW + SW + DW + DW + 1;

    logic                clock_100Khz = 1'b0;
    logic                reset;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_op_a;
    logic [N_REQ*DW-1:0] req_op_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_valid;
    logic [DW-1:0]       resp_data;
    logic [SW-1:0]       resp_status;
    logic                busy;
    logic                fpu_rst_n;
    logic [DW-1:0]       fpu_op_a;
    logic [DW-1:0]       fpu_op_b;
    logic [DW-1:0]       fpu_data_in;
    logic [SW-1:0]       fpu_status_in;
    logic [1:0]          state_dbg;

    fpu_rr_scheduler #(
        .N_REQ(N_REQ), .LATENCY(LATENCY), .DW(DW), .SW(SW)
    ) dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_status  (resp_status),
        .busy         (busy),
        .fpu_rst_n    (fpu_rst_n),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_data_in  (fpu_data_in),
        .fpu_status_in(fpu_status_in),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clock_100Khz = ~clock_100Khz;

    int   cyc = 0;
    logic rst_sampled = 1'b0;

    always @(posedge clock_100Khz) begin
        cyc         <= cyc + 1;
        rst_sampled <= reset;
    end

    // ---------------- stub FPU ----------------
    function automatic logic [DW-1:0] stub_data(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a == 32'h3FE0_0000 && b == 32'h3FE0_0000) return 32'h4000_0000;
        if (a == 32'h7FE0_0000 && b == 32'h0000_0001) return 32'h7FE0_0001;
        return a + {b[15:0], b[31:16]};
    endfunction

    function automatic logic [SW-1:0] stub_status(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a == 32'h3FE0_0000 && b == 32'h3FE0_0000) return 4'd0;
        if (a == 32'h7FE0_0000 && b == 32'h0000_0001) return 4'd3;
        return a[3:0] ^ b[7:4];
    endfunction

    // Result only becomes meaningful some cycles after the FPU leaves reset.
    int stub_cnt = 0;
    always @(posedge clock_100Khz) begin
        if (!fpu_rst_n) stub_cnt <= 0;
        else if (stub_cnt < 255) stub_cnt <= stub_cnt + 1;
    end
    assign fpu_data_in   = (stub_cnt >= 8) ? stub_data(fpu_op_a, fpu_op_b) : 32'hDEAD_BEEF;
    assign fpu_status_in = (stub_cnt >= 8) ? stub_status(fpu_op_a, fpu_op_b) : 4'hF;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0]    exp_q[$];
    logic [N_REQ-1:0] grant_seen = '0;
    int               m_ptr      = 0;
    int               m_idle_at  = 0;
    int               m_last_grant = -100;
    int               m_last_due   = -100;
    int               low_cnt    = 0;
    logic             have_resp  = 1'b0;
    logic [DW-1:0]    hold_data  = '0;
    logic [SW-1:0]    hold_status = '0;

    always @(negedge clock_100Khz) begin
        logic [N_REQ-1:0] exp_rdy;
        logic [EW-1:0]    ent;
        logic [31:0]      e_due;
        logic [7:0]       e_idx;
        logic [DW-1:0]    e_data, e_a, e_b, a, b, d;
        logic [SW-1:0]    e_status, s;
        logic             e_byp, byp, found;
        int               win, due;

        if (rst_sampled) begin
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_data", resp_data, 0);
            check("rst_resp_status", resp_status, 0);
            check("rst_busy", busy, 0);
            check("rst_fpu_rst_n", fpu_rst_n, 0);
            check("rst_fpu_op_a", fpu_op_a, 0);
            check("rst_fpu_op_b", fpu_op_b, 0);
            check("rst_state", state_dbg, 0);
            exp_q.delete();
            m_ptr        = 0;
            m_idle_at    = cyc;
            m_last_grant = -100;
            m_last_due   = -100;
            have_resp    = 1'b1;
            hold_data    = '0;
            hold_status  = '0;
        end

        if (!rst_sampled && !fpu_rst_n && cyc > m_last_grant) low_cnt++;

        // Responses that were due but never arrived.
        while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
            ent = exp_q.pop_front();
            check("resp_missing", 0, 1);
        end

        if (resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 0);
            end else begin
                ent = exp_q.pop_front();
                {e_due, e_idx, e_data, e_status, e_a, e_b, e_byp} = ent;
                check("resp_cycle", 32'(cyc), e_due);
                check("resp_owner", resp_valid, N_REQ'(1) << e_idx);
                check("resp_data", resp_data, e_data);
                check("resp_status", resp_status, e_status);
                check("fpu_rst_pulses", low_cnt, e_byp ? 0 : 1);
                if (!e_byp) begin
                    check("fpu_op_a", fpu_op_a, e_a);
                    check("fpu_op_b", fpu_op_b, e_b);
                end
                have_resp   = 1'b1;
                hold_data   = e_data;
                hold_status = e_status;
            end
        end else if (have_resp) begin
            check("hold_data", resp_data, hold_data);
            check("hold_status", resp_status, hold_status);
        end

        check("busy", busy, (cyc > m_last_grant) && (cyc <= m_last_due));

        // Arbitration: first valid requester at or after the pointer, wrapping.
        exp_rdy = '0;
        found   = 1'b0;
        win     = 0;
        if (!reset && cyc >= m_idle_at) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % N_REQ]) begin
                    found = 1'b1;
                    win   = (m_ptr + k) % N_REQ;
                end
            end
        end
        if (found) exp_rdy[win] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        grant_seen = req_ready;

        if (found) begin
            a   = req_op_a[win*DW +: DW];
            b   = req_op_b[win*DW +: DW];
            byp = 1'b0;
            d   = stub_data(a, b);
            s   = stub_status(a, b);
`ifdef FPU_SCHED_ZERO_BYPASS_EN
            if (b[DW-2:0] == '0) begin
                byp = 1'b1; d = a; s = '0;
            end else if (a[DW-2:0] == '0) begin
                byp = 1'b1; d = b; s = '0;
            end
`endif
            due = byp ? cyc + 1 : cyc + LATENCY + 3;
            exp_q.push_back({32'(due), 8'(win), d, s, a, b, byp});
            m_ptr        = (win + 1) % N_REQ;
            m_last_grant = cyc;
            m_last_due   = due;
            m_idle_at    = due;
            low_cnt      = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op_a[i*DW +: DW] = a;
        req_op_b[i*DW +: DW] = b;
        req_valid[i]         = 1'b1;
    endtask

    task automatic rand_ops(input int i);
        logic [DW-1:0] a, b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(7))
            0: b = 32'($urandom_range(1)) << 31;
            1: a = 32'($urandom_range(1)) << 31;
            default: ;
        endcase
        req_op_a[i*DW +: DW] = a;
        req_op_b[i*DW +: DW] = b;
    endtask

    // One clock: retire granted requests (optionally re-raise) and apply random traffic.
    task automatic step(input bit refill, input int pct, output logic [N_REQ-1:0] g);
        @(posedge clock_100Khz);
        #1;
        g = grant_seen;
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) begin
                req_valid[i] = refill;
                if (refill) rand_ops(i);
            end else if (pct > 0 && req_valid[i] && $urandom_range(99) < 2) begin
                req_valid[i] = 1'b0;
            end else if (pct > 0 && !req_valid[i] && $urandom_range(99) < pct) begin
                rand_ops(i);
                req_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic run(input int n, input bit refill, input int pct);
        logic [N_REQ-1:0] g;
        for (int t = 0; t < n; t++) step(refill, pct, g);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N_REQ-1:0] g;
        logic             got;

        reset     = 1'b1;
        req_valid = '0;
        req_op_a  = '0;
        req_op_b  = '0;
        run(3, 1'b0, 0);
        reset = 1'b0;

        // Single job with known stub result.
        set_req(0, 32'h3FE0_0000, 32'h3FE0_0000);
        run(40, 1'b0, 0);

        // Non-zero status, held until the next capture.
        set_req(2, 32'h7FE0_0000, 32'h0000_0001);
        run(45, 1'b0, 0);

        // Pointer at 2, then 1011 pending: expect 3, 0, 1.
        set_req(1, 32'h1111_1111, 32'h0101_0101);
        run(40, 1'b0, 0);
        set_req(0, 32'h0A0A_0A0A, 32'h5555_0000);
        set_req(1, 32'h1234_0000, 32'h0000_4321);
        set_req(3, 32'h3333_3333, 32'h4444_4444);
        run(3 * (LATENCY + 3) + 10, 1'b0, 0);

        // All requesters continuously valid.
        for (int i = 0; i < N_REQ; i++) begin
            rand_ops(i);
            req_valid[i] = 1'b1;
        end
        run(6 * (LATENCY + 3), 1'b1, 0);
        run(N_REQ * (LATENCY + 3) + 10, 1'b0, 0);

        // Zero B (negative zero): bypass when enabled, full FPU path otherwise.
        set_req(0, 32'h4100_0000, 32'h8000_0000);
        run(40, 1'b0, 0);

        // Reset while RUN has counter == 10; pending request 2 granted first afterwards.
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F);
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            step(1'b0, 0, g);
            if (g[1]) got = 1'b1;
        end
        check("grant_wait", got, 1);
        run(11, 1'b0, 0);
        reset = 1'b1;
        set_req(2, 32'h2222_2222, 32'h3333_3333);
        step(1'b0, 0, g);
        reset = 1'b0;
        run(45, 1'b0, 0);

        // Random traffic.
        run(2000, 1'b0, 30);
        run(N_REQ * (LATENCY + 3) + 20, 1'b0, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
